// File: rtl/dm_port.sv
// Data-memory port: turns the MEM stage's per-cycle load/store request into one
// word-wide req/ack transaction with big-endian byte lanes, stalling MEM until done.
module dm_port #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [31:0] Address_IN,
  input  logic [31:0] WriteData_IN,
  input  logic [1:0]  WriteSize_IN,
  output logic [31:0] ReadData_OUT,
  output logic        Stall_OUT,
  output logic        Misaligned_OUT,
  output logic        BusError_OUT,
  output logic        bm_req,
  output logic        bm_we,
  output logic [29:0] bm_addr,
  output logic [31:0] bm_wdata,
  output logic [3:0]  bm_be,
  input  logic        bm_ack,
  input  logic [31:0] bm_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] READ_POISON  = 32'hBADBADBA;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  // Request decode and big-endian lane placement
  logic        req_valid;
  logic [2:0]  n_bytes;
  logic [3:0]  span;
  logic        misaligned;
  logic [1:0]  lane_shift;
  logic [3:0]  be_base;
  logic [31:0] placed_wdata;
  logic [3:0]  placed_be;
  logic        accept;
  logic        timed_out;

  always_comb begin
    req_valid  = MemRead_IN | MemWrite_IN;
    n_bytes    = (WriteSize_IN == 2'd0) ? 3'd4 : {1'b0, WriteSize_IN};
    span       = {1'b0, n_bytes} + {2'b00, Address_IN[1:0]};
    misaligned = MemWrite_IN && (span > 4'd4);
    // Only meaningful when the store fits in the word (span <= 4)
    lane_shift = 2'(4'd4 - span);
    case (n_bytes)
      3'd1:    be_base = 4'b0001;
      3'd2:    be_base = 4'b0011;
      3'd3:    be_base = 4'b0111;
      default: be_base = 4'b1111;
    endcase
    placed_wdata = WriteData_IN << {lane_shift, 3'b000};
    placed_be    = be_base << lane_shift;
    accept       = (state_q == S_IDLE) && req_valid && !misaligned;
    timed_out    = (state_q == S_WAIT) && !bm_ack && (cnt_q == TIMEOUT_LAST);
  end

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bm_ack || timed_out) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bm_req    = (state_q == S_WAIT);
    Stall_OUT = accept || (state_q == S_WAIT);
  end

  // Transaction datapath: captured on accept, frozen while waiting
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d  = 8'd0;
          we_d   = MemWrite_IN;
          addr_d = Address_IN[31:2];
          if (MemWrite_IN) begin
            wdata_d = placed_wdata;
            be_d    = placed_be;
          end else begin
            wdata_d = 32'd0;
            be_d    = 4'b1111;
          end
        end else if (req_valid && misaligned) begin
          mis_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (bm_ack) begin
          if (!we_q) begin
            rdata_d = bm_rdata;
          end
        end else if (timed_out) begin
          berr_d = 1'b1;
          if (!we_q) begin
            rdata_d = READ_POISON;
          end
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 30'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign bm_we          = we_q;
  assign bm_addr        = addr_q;
  assign bm_wdata       = wdata_q;
  assign bm_be          = be_q;
  assign ReadData_OUT   = rdata_q;
  assign Misaligned_OUT = mis_q;
  assign BusError_OUT   = berr_q;

endmodule

// File: doc/dm_port.md
# dm_port

Data-memory port controller between the MEM stage and a multi-cycle backing data memory. It takes MEM's per-cycle memory request and issues it as one word-wide transaction with byte enables on a req/ack handshake. It stalls the pipeline until the transaction completes and returns the raw read word to MEM through `data_read_fDM`, where MEM performs the sub-word extraction. It also detects illegal partial-word writes and backing-memory timeouts.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: cycles `bm_req` may stay unacknowledged before the transaction is abandoned; legal range 2..255.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  reset. One clock; reset is synchronous and active-high.
- MemRead_IN  in  1  load request (from MEM_2DM).
- MemWrite_IN  in  1  store request; wins if both are asserted.
- Address_IN  in  32  byte address (data_address_2DM).
- WriteData_IN  in  32  store data, right-justified (data_write_2DM).
- WriteSize_IN  in  2  store byte count: 0=4, 1=1, 2=2, 3=3.
- ReadData_OUT  out  32  raw word of the last completed read (to data_read_fDM).
- Stall_OUT  out  1  pipeline must hold all stage registers.
- Misaligned_OUT  out  1  one-cycle pulse: write rejected.
- BusError_OUT  out  1  one-cycle pulse: timeout.
- bm_req  out  1  transaction valid.
- bm_we  out  1  1=write, 0=read.
- bm_addr  out  30  word address, Address_IN[31:2].
- bm_wdata  out  32  lane-placed write data.
- bm_be  out  4  byte enables; be[i] enables bits [8i+7:8i].
- bm_ack  in  1  backing memory completes the transaction this cycle.
- bm_rdata  in  32  read word, valid when bm_ack && !bm_we.

## Operation
- Byte order is big-endian. Byte offset k = Address_IN[1:0] maps to bits [31-8k:24-8k], which is be[3-k].
- Write placement: n = byte count and o = offset.
  - bm_wdata = WriteData_IN << 8*(4-n-o).
  - bm_be has bits 3-o down to 4-o-n set.
  - If o+n > 4, the write is misaligned.
- Reads always fetch the full word, with bm_be = 4'b1111.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Misaligned write: pulse Misaligned_OUT, no transaction, stay in IDLE.
    - Otherwise: register bm_addr, bm_we, bm_wdata and bm_be; clear the timeout counter; go to WAIT.
  - WAIT:
    - bm_req = 1 and all bm_* outputs are held stable.
    - bm_ack: a read latches bm_rdata into ReadData_OUT. Go to DONE.
    - Counter reaches TIMEOUT_CYCLES-1 without ack: pulse BusError_OUT. A read sets ReadData_OUT = 32'hBADBADBA. Go to DONE.
  - DONE: Stall_OUT = 0; unconditionally return to IDLE next cycle. The inputs still presented in DONE are the completed request and must not be reissued.
- Stall_OUT is combinational: (IDLE && valid non-misaligned request) || WAIT.
- bm_ack outside WAIT is ignored.
- ReadData_OUT holds its value across writes, misaligned pulses and idle cycles.
- The timeout counter is 8 bits and saturates; it does not wrap.

## Timing
- Reset values:
  - State = IDLE.
  - bm_req, bm_we, Misaligned_OUT, BusError_OUT = 0.
  - bm_addr, bm_wdata, ReadData_OUT = 0.
  - bm_be = 0.
  - Stall_OUT = 0 (IDLE with no request evaluated after reset).
- Request seen in cycle 0 (IDLE):
  - Stall_OUT = 1 in cycle 0.
  - bm_req = 1 from cycle 1.
  - bm_ack sampled in cycle k ≥ 1; DONE in cycle k+1.
  - Stall_OUT = 0 in cycle k+1, and the pipeline advances on that edge.
- Minimum latency: ack in cycle 1 gives a 2-cycle stall and data in cycle 2.
- Back-to-back requests:
  - The next request is accepted in the IDLE cycle after DONE.
  - The maximum rate is one transaction per 3 cycles.
- Misaligned write: Misaligned_OUT = 1 in the cycle after detection; no stall cycle.
- Timeout: BusError_OUT = 1 in the DONE cycle, TIMEOUT_CYCLES cycles after bm_req rose.
- Reset mid-transaction:
  - bm_req drops on the next edge and the state returns to IDLE.
  - A late bm_ack is ignored.
  - ReadData_OUT is cleared.

## Test plan
- Reset, then a read at 0x0000_0104 with ack after 3 cycles, bm_rdata=0xA1B2C3D4:
  - bm_addr=0x41 and bm_be=1111.
  - Stall is high for 4 cycles.
  - ReadData_OUT=0xA1B2C3D4 in DONE.
- Byte and halfword writes:
  - SB at 0x...03, data 0x000000AB: bm_wdata=0x000000AB, bm_be=0001, bm_we=1.
  - SH at 0x...00, data 0x00001234: bm_wdata=0x12340000, bm_be=1100.
- 3-byte write at offset 1, data 0x00112233: bm_wdata=0x00112233, bm_be=0111.
  - Same size at offset 2: Misaligned_OUT pulses, bm_req stays 0, Stall_OUT stays 0.
- Timeout: read with TIMEOUT_CYCLES=4 and bm_ack never asserted:
  - BusError_OUT pulses once.
  - ReadData_OUT=0xBADBADBA.
  - Stall is released after 5 cycles.
- RESET asserted in the 2nd WAIT cycle, then bm_ack the following cycle:
  - bm_req=0, state IDLE, ReadData_OUT=0.
  - The ack is ignored.
- Simultaneous MemRead_IN and MemWrite_IN at 0x...00, size 0:
  - Performed as a write with bm_we=1 and bm_be=1111.
  - A spurious bm_ack in IDLE changes nothing.
